// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
//
// Purpose: horizontal/vertical raster counters advanced by an internal
// pixel-clock-enable divider. Position, sync, blanking and strobes are all
// registered on the same edge, so they are always mutually coherent.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pix_ce       high in the clk cycle whose rising edge advances the raster
//   hpos, vpos   current pixel column / line
//   hsync, vsync sync outputs, active level set by HSYNC_ACTIVE / VSYNC_ACTIVE
//   display_on   high inside the visible area
//   line_start   one-clk strobe after the edge that enters column 0
//   frame_start  one-clk strobe after the edge that enters (0,0)
//   frame_count  completed-frame counter (first frame after reset is 0)

module vga_timing_gen #(
    parameter int   H_DISPLAY    = 640,
    parameter int   H_FRONT      = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BACK       = 48,
    parameter int   V_DISPLAY    = 480,
    parameter int   V_BOTTOM     = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_TOP        = 33,
    parameter logic HSYNC_ACTIVE = 1'b0,
    parameter logic VSYNC_ACTIVE = 1'b0,
    parameter int   CLK_DIV      = 1,
    parameter int   H_W          = 10,
    parameter int   V_W          = 10,
    parameter int   FRAME_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_ce,
    output logic [H_W-1:0]     hpos,
    output logic [V_W-1:0]     vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [H_W-1:0] H_MAX    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS    = H_W'(H_DISPLAY);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_DISPLAY + H_FRONT);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);

    localparam logic [V_W-1:0] V_MAX    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS    = V_W'(V_DISPLAY);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    // A one-bit divider is kept even for CLK_DIV=1; it then never leaves 0.
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_next;
    logic [V_W-1:0]   v_next;
    logic             h_wrap;
    logic             at_origin;
    logic             first_frame;

    assign pix_ce = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (pix_ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Next raster position; sync/blank are derived from it rather than from
    // the current position so they land on the same edge as hpos/vpos.
    always_comb begin
        h_wrap = (hpos == H_MAX);
        h_next = h_wrap ? '0 : hpos + H_W'(1);
        v_next = vpos;
        if (h_wrap) begin
            v_next = (vpos == V_MAX) ? '0 : vpos + V_W'(1);
        end
        at_origin = (h_next == '0) && (v_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos        <= H_MAX;
            vpos        <= V_MAX;
            hsync       <= ~HSYNC_ACTIVE;
            vsync       <= ~VSYNC_ACTIVE;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            first_frame <= 1'b1;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                hpos        <= h_next;
                vpos        <= v_next;
                hsync       <= (h_next >= HS_FIRST && h_next <= HS_LAST) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
                vsync       <= (v_next >= VS_FIRST && v_next <= VS_LAST) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
                display_on  <= (h_next < H_VIS) && (v_next < V_VIS);
                line_start  <= (h_next == '0);
                frame_start <= at_origin;
                // The frame entered right after reset is frame 0, so only
                // later frame starts bump the counter.
                if (at_origin) begin
                    if (first_frame) begin
                        first_frame <= 1'b0;
                    end else begin
                        frame_count <= frame_count + FRAME_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: a configurable horizontal/vertical counter pair with selectable sync polarity, an internal pixel-clock-enable divider, line/frame start strobes and a frame counter. It sits between the system clock and the pixel/colour logic in every VGA top level, and supplies registered position, sync and blanking signals that are mutually cycle-coherent.

## Interface
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BACK, 48: horizontal back porch (pixels), must be ≥1
- V_DISPLAY, 480: visible lines
- V_BOTTOM, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_TOP, 33: vertical back porch (lines), must be ≥1
- HSYNC_ACTIVE, 0: hsync level during sync pulse (0 = active-low)
- VSYNC_ACTIVE, 0: vsync level during sync pulse
- CLK_DIV, 1: clk cycles per pixel, ≥1
- H_W, 10 / V_W, 10: hpos/vpos widths; must hold H_MAX / V_MAX
- FRAME_W, 8: frame counter width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_ce  out  1  high in the clk cycle whose rising edge advances the raster
- hpos  out  H_W  current pixel column
- vpos  out  V_W  current line
- hsync  out  1  horizontal sync, polarity per HSYNC_ACTIVE
- vsync  out  1  vertical sync, polarity per VSYNC_ACTIVE
- display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  out  1  one-clk strobe, high while hpos==0 right after a tick
- frame_start  out  1  one-clk strobe, high while (hpos,vpos)==(0,0) right after a tick
- frame_count  out  FRAME_W  completed-frame counter

## Operation
- Derived: H_MAX=H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1; V_MAX likewise; H sync range [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; V sync range analogous.
- Divider: div_cnt counts 0..CLK_DIV-1, wraps; pix_ce = (div_cnt==CLK_DIV-1), combinational. CLK_DIV=1 → pix_ce constantly 1 out of reset.
- On a clk edge with pix_ce=1: hpos increments; at H_MAX wraps to 0 and vpos increments; vpos at V_MAX wraps to 0. Without pix_ce all counters/outputs hold (strobes drop to 0).
- hsync, vsync, display_on registered and computed from the next position at the same edge: invariant every cycle — hsync==HSYNC_ACTIVE iff hpos in H sync range; same for vsync; display_on matches hpos/vpos. No skew between position and sync.
- line_start/frame_start registered, asserted for exactly one clk after the advancing edge.
- frame_count: increments (mod 2^FRAME_W) on every frame_start except the first after reset; first frame after reset is frame 0.

## Timing
- Reset (async, immediate): div_cnt=0, hpos=H_MAX, vpos=V_MAX, hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE, display_on=0, line_start=0, frame_start=0, frame_count=0, first-frame flag set. Invariant holds during reset.
- After reset release: first advancing edge is the CLK_DIV-th rising edge; it produces (0,0), display_on=1, line_start=frame_start=1, frame_count stays 0.
- Line period = (H_MAX+1)·CLK_DIV clks; frame period = (H_MAX+1)(V_MAX+1)·CLK_DIV clks.
- Reset asserted mid-frame: all state returns to reset values asynchronously; resumes as above.
- frame_count wraps from 2^FRAME_W-1 to 0 without other effect.

## Test plan
- Default params, CLK_DIV=1: release reset → next edge hpos=0,vpos=0, frame_start=1, frame_count=0; 800 clks later line_start=1, vpos=1.
- Sync check: hsync low exactly for hpos 656..751 (96 clks/line), vsync low exactly for vpos 490..491; display_on high 640×480 pixels per frame; invariant asserted every cycle.
- CLK_DIV=4: pix_ce 1 in every 4th clk; hpos steps once per 4 clks; line period 3200 clks; strobes one clk wide.
- HSYNC_ACTIVE=1, VSYNC_ACTIVE=1: sync levels inverted vs default, idle low in reset.
- FRAME_W=2, small raster (H 8/1/2/1, V 4/1/1/1): frame_count 0,1,2,3,0 over five frame_starts.
- Assert reset at hpos=300,vpos=200 for 3 clks: outputs immediately at reset values; after release frame restarts at (0,0), frame_count=0.
